// File: rtl/ps2_pkg.sv
// ps2_pkg: shared definitions for the PS/2 host transmitter.
//   ps2_state_e : transmitter FSM states
//   us2cyc()    : microseconds -> system clock cycles at a given clock rate
//   odd_par()   : odd parity bit for one data byte
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_REQ,
    ST_SEND,
    ST_ACK,
    ST_WAITIDLE
  } ps2_state_e;

  // 64-bit intermediate so CLKHZ * us cannot overflow
  function automatic int unsigned us2cyc(input int unsigned hz, input int unsigned us);
    longint unsigned p;
    p = 64'(hz) * 64'(us);
    return 32'(p / 64'd1000000);
  endfunction

  function automatic logic odd_par(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// ps2_line_sync: input conditioning for one PS/2 pin.
//   Two-flop synchronizer, optional glitch filter, falling-edge detect.
//   Build option PS2TX_FILTER_EN: the level is accepted only after 8
//   consecutive equal synchronized samples (adds 8 cycles of latency).
// Ports:
//   clk_i   system clock
//   rst_i   synchronous active-high reset (level resets to idle-high)
//   pin_i   asynchronous pin level
//   lvl_o   conditioned level
//   fall_o  one-cycle pulse on a 1->0 transition of lvl_o
module ps2_line_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic pin_i,
  output logic lvl_o,
  output logic fall_o
);

  logic s1_q, s2_q, prev_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q   <= 1'b1;
      s2_q   <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      s1_q   <= pin_i;
      s2_q   <= s1_q;
      prev_q <= lvl_o;
    end
  end

`ifdef PS2TX_FILTER_EN
  logic       filt_q;
  logic [2:0] run_q;

  // run_q counts consecutive samples that disagree with the accepted level
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      filt_q <= 1'b1;
      run_q  <= '0;
    end else if (s2_q == filt_q) begin
      run_q <= '0;
    end else if (run_q == 3'd7) begin
      filt_q <= s2_q;
      run_q  <= '0;
    end else begin
      run_q <= run_q + 3'd1;
    end
  end

  assign lvl_o = filt_q;
`else
  assign lvl_o = s2_q;
`endif

  assign fall_o = prev_q & ~lvl_o;

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device transmitter for one command byte.
//   Pulls clock low (inhibit), asserts the start bit, releases clock, then
//   shifts data[0..7], odd parity and stop out on device falling edges and
//   checks the device ack. Lines are driven through active-high pull-low
//   enables. Build option PS2TX_FILTER_EN adds a glitch filter on the inputs.
// Ports:
//   clock32  system clock          reset    synchronous active-high reset
//   ps2Ck    clock pin level       ps2Dq    data pin level
//   ps2CkOe  1 = pull clock low    ps2DqOe  1 = pull data low
//   start    one-cycle request     data     byte to send
//   busy     frame in progress     done     ack received, lines idle (pulse)
//   error    timeout or no ack (pulse)
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned CLKHZ       = 32000000,
  parameter int unsigned INHIBIT_US  = 120,
  parameter int unsigned START_US    = 16,
  parameter int unsigned TOUT_REQ_US = 15000,
  parameter int unsigned TOUT_FRM_US = 2000
) (
  input  logic       clock32,
  input  logic       reset,
  input  logic       ps2Ck,
  input  logic       ps2Dq,
  output logic       ps2CkOe,
  output logic       ps2DqOe,
  input  logic       start,
  input  logic [7:0] data,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int unsigned INH_CYC   = us2cyc(CLKHZ, INHIBIT_US);
  localparam int unsigned START_CYC = us2cyc(CLKHZ, START_US);
  localparam int unsigned REQ_CYC   = us2cyc(CLKHZ, TOUT_REQ_US);
  localparam int unsigned FRM_CYC   = us2cyc(CLKHZ, TOUT_FRM_US);
  localparam int unsigned TOUT_MAX  = (REQ_CYC > FRM_CYC) ? REQ_CYC : FRM_CYC;
  localparam int unsigned IW        = $clog2(INH_CYC);
  localparam int unsigned TW        = $clog2(TOUT_MAX);

  logic ck_lvl, ck_fall, dq_lvl, dq_fall_unused;

  ps2_line_sync u_ck_sync (
    .clk_i  (clock32),
    .rst_i  (reset),
    .pin_i  (ps2Ck),
    .lvl_o  (ck_lvl),
    .fall_o (ck_fall)
  );

  ps2_line_sync u_dq_sync (
    .clk_i  (clock32),
    .rst_i  (reset),
    .pin_i  (ps2Dq),
    .lvl_o  (dq_lvl),
    .fall_o (dq_fall_unused)
  );

  ps2_state_e    state_q, state_d;
  logic [8:0]    shift_q, shift_d;
  logic [3:0]    bit_q, bit_d;
  logic [IW-1:0] inh_q, inh_d;
  logic [TW-1:0] tout_q, tout_d;
  logic          ckoe_q, ckoe_d, dqoe_q, dqoe_d;
  logic          busy_q, busy_d, done_q, done_d, err_q, err_d;

  always_ff @(posedge clock32) begin
    if (reset) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      inh_q   <= '0;
      tout_q  <= '0;
      ckoe_q  <= 1'b0;
      dqoe_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      inh_q   <= inh_d;
      tout_q  <= tout_d;
      ckoe_q  <= ckoe_d;
      dqoe_q  <= dqoe_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    inh_d   = inh_q;
    tout_d  = tout_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          shift_d = {odd_par(data), data};
          bit_d   = '0;
          inh_d   = IW'(INH_CYC - 1);
          state_d = ST_INHIBIT;
        end
      end
      ST_INHIBIT: begin
        if (inh_q == '0) begin
          tout_d  = TW'(REQ_CYC - 1);
          state_d = ST_REQ;
        end else begin
          inh_d = inh_q - 1'b1;
        end
      end
      default: begin
        // Timeout has priority over a coincident device clock edge
        if (tout_q == '0) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          tout_d = tout_q - 1'b1;
          case (state_q)
            ST_REQ: begin
              if (ck_fall) begin
                tout_d  = TW'(FRM_CYC - 1);
                state_d = ST_SEND;
              end
            end
            ST_SEND: begin
              // Shift in 1s from the top: after parity leaves, bit0 is the stop bit
              if (ck_fall) begin
                shift_d = {1'b1, shift_q[8:1]};
                bit_d   = bit_q + 4'd1;
                if (bit_q == 4'd8) state_d = ST_ACK;
              end
            end
            ST_ACK: begin
              if (ck_fall) begin
                if (dq_lvl) begin
                  err_d   = 1'b1;
                  state_d = ST_IDLE;
                end else begin
                  state_d = ST_WAITIDLE;
                end
              end
            end
            ST_WAITIDLE: begin
              if (ck_lvl && dq_lvl) begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
              end
            end
            default: ;
          endcase
        end
      end
    endcase

    // Line enables are registered from the next state so they track it exactly
    ckoe_d = (state_d == ST_INHIBIT);
    case (state_d)
      ST_INHIBIT: dqoe_d = (inh_d < IW'(START_CYC));
      ST_REQ:     dqoe_d = 1'b1;
      ST_SEND:    dqoe_d = ~shift_d[0];
      default:    dqoe_d = 1'b0;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  assign ps2CkOe = ckoe_q;
  assign ps2DqOe = dqoe_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign error   = err_q;

endmodule
